// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the serial adder: the requester drives start and operands,
// the adder returns status and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin computed DIGIT bits per clock, LSB slice first,
// with a start/busy/done handshake and a result held until the next completion.
module serial_adder #(
    parameter int WIDTH  = 8,
    parameter int DIGIT  = 1,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, acc_reg, sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, cout_reg, ovf_reg, done_reg;

    logic             accept, last_slice, busy_int;
    logic [DIGIT-1:0] a_slice, b_slice;
    logic [DIGIT:0]   slice_res;
    logic [WIDTH-1:0] acc_merged;
    logic             msb_cin;

    assign accept     = (state_reg == IDLE) && bus.start;
    assign last_slice = (cnt_reg == LAST);

    // One slice of the ripple: the slice selected by the counter plus the running carry.
    assign a_slice   = a_reg[int'(cnt_reg)*DIGIT +: DIGIT];
    assign b_slice   = b_reg[int'(cnt_reg)*DIGIT +: DIGIT];
    assign slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, carry_reg};

    // Carry into the top bit of the slice; on the last slice this is the carry into the MSB.
    assign msb_cin = a_slice[DIGIT-1] ^ b_slice[DIGIT-1] ^ slice_res[DIGIT-1];

    always_comb begin
        acc_merged = acc_reg;
        acc_merged[int'(cnt_reg)*DIGIT +: DIGIT] = slice_res[DIGIT-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_slice) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_int = (state_reg == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                a_reg     <= bus.a;
                b_reg     <= bus.b;
                carry_reg <= bus.cin;
                cnt_reg   <= '0;
                acc_reg   <= '0;
            end else if (state_reg == RUN) begin
                acc_reg   <= acc_merged;
                carry_reg <= slice_res[DIGIT];
                cnt_reg   <= cnt_reg + 1'b1;
                // Result registers only move here, so they stay stable while busy.
                if (last_slice) begin
                    sum_reg  <= acc_merged;
                    cout_reg <= slice_res[DIGIT];
                    ovf_reg  <= (SIGNED != 0) ? (msb_cin ^ slice_res[DIGIT]) : slice_res[DIGIT];
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = busy_int;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three WIDTH=8 instances (DIGIT=1 unsigned, DIGIT=1 signed,
// DIGIT=4 unsigned) driven by directed and random stimulus, checked against an arithmetic model.
module tb_serial_adder;
    localparam int W = 8;
    localparam int N = 3;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_v [N];
    logic [W-1:0] a_v     [N];
    logic [W-1:0] b_v     [N];
    logic         cin_v   [N];
    logic         busy_v  [N];
    logic         done_v  [N];
    logic [W-1:0] sum_v   [N];
    logic         cout_v  [N];
    logic         ovf_v   [N];

    exp_t sb [N][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int dig_of(input int i);
        return (i == 2) ? 4 : 1;
    endfunction

    function automatic bit sgn_of(input int i);
        return (i == 1);
    endfunction

    // Reference: plain integer addition, overflow from operand/result signs.
    function automatic exp_t model(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input int k);
        exp_t        e;
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        e.sum  = t[W-1:0];
        e.cout = t[W];
        if (sgn_of(i)) e.ovf = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
        else           e.ovf = e.cout;
        e.cyc = k + W / dig_of(i);
        return e;
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int D = (gi == 2) ? 4 : 1;
        localparam int S = (gi == 1) ? 1 : 0;

        serial_adder_if #(.WIDTH(W)) bus ();

        assign bus.start  = start_v[gi];
        assign bus.a      = a_v[gi];
        assign bus.b      = b_v[gi];
        assign bus.cin    = cin_v[gi];
        assign busy_v[gi] = bus.busy;
        assign done_v[gi] = bus.done;
        assign sum_v[gi]  = bus.sum;
        assign cout_v[gi] = bus.cout;
        assign ovf_v[gi]  = bus.ovf;

        serial_adder #(.WIDTH(W), .DIGIT(D), .SIGNED(S)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        logic [W-1:0] last_sum;
        exp_t         e;

        always @(negedge clk) begin
            if (!rst) begin
                if (done_v[gi]) begin
                    checks++;
                    if (sb[gi].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done[%0d] cyc=%0d sum=%02h required no done", gi, cyc, sum_v[gi]);
                    end else begin
                        e = sb[gi].pop_front();
                        if (sum_v[gi] !== e.sum || cout_v[gi] !== e.cout || ovf_v[gi] !== e.ovf || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL result[%0d] got sum=%02h cout=%0b ovf=%0b cyc=%0d required sum=%02h cout=%0b ovf=%0b cyc=%0d",
                                     gi, sum_v[gi], cout_v[gi], ovf_v[gi], cyc, e.sum, e.cout, e.ovf, e.cyc);
                        end else begin
                            $display("txn[%0d] cyc=%0d sum=%02h cout=%0b ovf=%0b ok", gi, cyc, e.sum, e.cout, e.ovf);
                        end
                    end
                end else begin
                    checks++;
                    if (sum_v[gi] !== last_sum) begin
                        errors++;
                        $display("FAIL sum_stable[%0d] cyc=%0d got %02h required %02h", gi, cyc, sum_v[gi], last_sum);
                    end
                end
            end
            last_sum = sum_v[gi];
        end
    end

    task automatic check_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({busy_v[i], done_v[i], sum_v[i], cout_v[i], ovf_v[i]} !== '0) begin
                errors++;
                $display("FAIL %s[%0d] got busy=%0b done=%0b sum=%02h cout=%0b ovf=%0b required all 0",
                         tag, i, busy_v[i], done_v[i], sum_v[i], cout_v[i], ovf_v[i]);
            end
        end
    endtask

    // Reset asserted off the clock edge to exercise the asynchronous path.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            sb[i].delete();
            start_v[i] = 1'b0;
        end
        #1;
        check_zero("reset_async");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_release");
    endtask

    task automatic issue(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_v[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy_v[i]) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout[%0d] busy=%0b required 0", i, busy_v[i]);
            return;
        end
        a_v[i]     = x;
        b_v[i]     = y;
        cin_v[i]   = c;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        a_v[i]     = W'($urandom);
        b_v[i]     = W'($urandom);
        cin_v[i]   = 1'($urandom);
        checks++;
        if (busy_v[i] !== 1'b1) begin
            errors++;
            $display("FAIL accept[%0d] busy=%0b required 1", i, busy_v[i]);
        end
        sb[i].push_back(model(i, x, y, c, cyc));
    endtask

    task automatic rand_run(input int i, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(i, W'($urandom), W'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
            cin_v[i]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        issue(0, 8'h00, 8'h00, 1'b0);
        issue(0, 8'hFF, 8'h01, 1'b0);
        issue(0, 8'h12, 8'h34, 1'b1);
        issue(1, 8'h7F, 8'h01, 1'b0);
        issue(1, 8'h80, 8'hFF, 1'b0);
        issue(2, 8'hA5, 8'h5A, 1'b1);

        // start while busy must be ignored; the follow-up start lands on the done cycle
        issue(0, 8'h10, 8'h20, 1'b0);
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 8'hFF;
        b_v[0]     = 8'hFF;
        @(negedge clk);
        start_v[0] = 1'b0;
        issue(0, 8'h01, 8'h01, 1'b0);
        issue(0, 8'h01, 8'h01, 1'b0);

        // abort mid-run: reset during slice 3, then a clean addition
        issue(0, 8'h0F, 8'h01, 1'b0);
        repeat (2) @(posedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        check_zero("after_abort");
        issue(0, 8'h0F, 8'h01, 1'b0);

        fork
            rand_run(0, 25);
            rand_run(1, 25);
            rand_run(2, 40);
        join

        n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", sb[0].size() + sb[1].size() + sb[2].size());
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder; successor to the single-bit combinational half adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB slice first.
- Uses a start/busy/done handshake. Results are registered and held until the next accepted start.
- Used where a narrow adder shared over time is preferred to a wide ripple-carry adder.

Parameters:
- WIDTH, 8: operand and sum width in bits. Must be >= 2.
- DIGIT, 1: bits added per cycle. Must divide WIDTH exactly. STEPS = WIDTH/DIGIT.
- SIGNED, 0: selects the ovf meaning. 0 = unsigned overflow, 1 = two's-complement overflow.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled only when idle
- a  in  WIDTH  operand A; captured on accepted start
- b  in  WIDTH  operand B; captured on accepted start
- cin  in  1  carry-in; captured on accepted start
- busy  out  1  high while an addition is in progress
- done  out  1  one-cycle pulse; result outputs valid
- sum  out  WIDTH  result of last completed addition
- cout  out  1  carry out of the MSB of the last result
- ovf  out  1  overflow flag of the last result

Behaviour:
- Reset (asynchronous, any time):
  - State goes to IDLE; slice counter and internal registers clear.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Reset mid-operation aborts the addition: no done pulse, no partial result visible.
- FSM has two states, IDLE and RUN.
- IDLE, start=1 at edge k (accept):
  - Capture a, b, cin into operand registers and the carry register.
  - Clear the slice counter and partial accumulator.
  - busy=1 from edge k; state goes to RUN.
- RUN, edges k+1 .. k+STEPS:
  - Slice i (bits i*DIGIT .. i*DIGIT+DIGIT-1) is computed as a_slice + b_slice + carry, a (DIGIT+1)-bit result.
  - The low DIGIT bits are written into the accumulator at slice i.
  - The MSB of the result becomes the new carry.
  - The counter increments.
- At edge k+STEPS (last slice):
  - sum <= accumulator with the final slice merged in.
  - cout <= final carry.
  - ovf <= final carry when SIGNED=0; (carry into MSB) XOR (carry out of MSB) when SIGNED=1.
  - done=1 for exactly one cycle; busy=0; state goes to IDLE.
- Latency: done rises STEPS cycles after the accepting edge. Examples: WIDTH=8, DIGIT=1 gives 8 cycles; DIGIT=4 gives 2 cycles.
- start while busy=1 is ignored; operands are not re-captured and the current result is unaffected.
- start=1 in the cycle done=1 (state IDLE) is accepted. Back-to-back throughput is one result per STEPS+1 cycles.
- Holding start high continuously re-launches after every completion.
- sum, cout and ovf change only at completion edges or reset. They are stable between completions and while busy.
- All arithmetic is modulo 2^WIDTH. The carry-out is not part of sum.
- Inputs a, b and cin may change freely after acceptance without affecting the result.

Test Plan:
- WIDTH=8, DIGIT=1: assert rst mid-sim, then release → all outputs 0, busy=0. Then a=0x00, b=0x00, cin=0, start pulse → busy high 8 cycles, done pulse, sum=0x00, cout=0, ovf=0.
- WIDTH=8, DIGIT=1, SIGNED=0: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=1. Then a=0x12, b=0x34, cin=1 → sum=0x47, cout=0, ovf=0.
- WIDTH=8, SIGNED=1: a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0xFF → sum=0x7F, cout=1, ovf=1.
- WIDTH=8, DIGIT=4: a=0xA5, b=0x5A, cin=1 → done 2 cycles after accept, sum=0x00, cout=1.
- Protocol: during a 0x10+0x20 run, pulse start with a=0xFF → ignored, sum=0x30. Start asserted on the done cycle with a=0x01, b=0x01 → accepted, next sum=0x02.
- Reset mid-run: start 0x0F+0x01, assert rst at slice 3 → no done pulse, sum=0, busy=0. After release, a new start completes normally.
